// File: rtl/branch_hazard_controller_pkg.sv
// Shared MIPS definitions: branch-kind codes, hazard FSM states and stall-depth codes.
// Latency: n/a (types only); backpressure: n/a.
package branch_hazard_controller_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JR   = 3'd1,
        BR_JALR = 3'd2,
        BR_BEQ  = 3'd3,
        BR_BNE  = 3'd4,
        BR_J    = 3'd5
    } branch_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_e;

    localparam logic [1:0] STALL_NONE = 2'd0;
    localparam logic [1:0] STALL_ONE  = 2'd1;
    localparam logic [1:0] STALL_TWO  = 2'd2;

endpackage

// File: rtl/branch_hazard_controller_detector.sv
// Combinational branch operand hazard check: returns the stall depth (0/1/2) for the ID branch.
// Latency: 0 cycles; backpressure: none, pure function of its inputs.
module branch_hazard_detector
    import branch_hazard_controller_pkg::*;
#(
    parameter int CANT_BITS_FLAG_BRANCH       = 3,
    parameter int CANT_BITS_ADDRESS_REGISTROS = 5
) (
    input  logic [CANT_BITS_FLAG_BRANCH-1:0]       i_flag_branch,
    input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_rs,
    input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_rt,
    input  logic                                   i_ex_reg_write,
    input  logic                                   i_ex_mem_read,
    input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_ex_rd,
    input  logic                                   i_mem_mem_read,
    input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_mem_rd,
    output logic                                   o_branch_active,
    output logic [1:0]                             o_stall_count
);

    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] K_JR  = CANT_BITS_FLAG_BRANCH'(BR_JR);
    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] K_BEQ = CANT_BITS_FLAG_BRANCH'(BR_BEQ);
    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] K_BNE = CANT_BITS_FLAG_BRANCH'(BR_BNE);
    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] K_J   = CANT_BITS_FLAG_BRANCH'(BR_J);

    logic rt_used;
    logic dep_ex;
    logic dep_mem;

    always_comb begin
        o_branch_active = (i_flag_branch >= K_JR) && (i_flag_branch <= K_J);
        // Only the compare branches read rt; jumps and JR/JALR read rs alone.
        rt_used = (i_flag_branch == K_BEQ) || (i_flag_branch == K_BNE);
        dep_ex  = (i_ex_rd != '0) &&
                  ((i_rs == i_ex_rd) || (rt_used && (i_rt == i_ex_rd)));
        dep_mem = (i_mem_rd != '0) &&
                  ((i_rs == i_mem_rd) || (rt_used && (i_rt == i_mem_rd)));

        o_stall_count = STALL_NONE;
        if (o_branch_active) begin
            if (i_ex_mem_read && dep_ex) begin
                o_stall_count = STALL_TWO;
            end else if ((i_ex_reg_write && dep_ex) || (i_mem_mem_read && dep_mem)) begin
                o_stall_count = STALL_ONE;
            end
        end
    end

endmodule

// File: rtl/branch_hazard_controller.sv
// ID-stage branch hazard controller: stalls on operand hazards, redirects PC on taken branches, keeps stats.
// Latency: stall is combinational in the detection cycle, redirect 1 cycle after resolution; i_enable_etapa=0 freezes all.
module branch_hazard_controller
    import branch_hazard_controller_pkg::*;
#(
    parameter int CANT_BITS_ADDR              = 11,
    parameter int CANT_BITS_FLAG_BRANCH       = 3,
    parameter int CANT_BITS_ADDRESS_REGISTROS = 5,
    parameter int CANT_BITS_CONTADOR          = 16
) (
    input  logic                                   i_clock,
    input  logic                                   i_reset,
    input  logic                                   i_enable_etapa,
    input  logic [CANT_BITS_FLAG_BRANCH-1:0]       i_flag_branch,
    input  logic                                   i_branch_control,
    input  logic [CANT_BITS_ADDR-1:0]              i_branch_dir,
    input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_rs,
    input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_rt,
    input  logic                                   i_ex_reg_write,
    input  logic                                   i_ex_mem_read,
    input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_ex_rd,
    input  logic                                   i_mem_mem_read,
    input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_mem_rd,
    output logic                                   o_stall,
    output logic                                   o_pc_load,
    output logic [CANT_BITS_ADDR-1:0]              o_pc_target,
    output logic                                   o_flush_if_id,
    output logic [CANT_BITS_CONTADOR-1:0]          o_branch_count,
    output logic [CANT_BITS_CONTADOR-1:0]          o_taken_count
);

    hz_state_e                     state_q, state_d;
    logic [1:0]                    stall_cnt_q, stall_cnt_d;
    logic [CANT_BITS_ADDR-1:0]     pc_target_q, pc_target_d;
    logic [CANT_BITS_CONTADOR-1:0] branch_count_q, branch_count_d;
    logic [CANT_BITS_CONTADOR-1:0] taken_count_q, taken_count_d;

    logic       branch_active;
    logic [1:0] stall_need;
    logic       run;

    function automatic logic [CANT_BITS_CONTADOR-1:0] sat_inc(
        input logic [CANT_BITS_CONTADOR-1:0] v
    );
        return (&v) ? v : v + CANT_BITS_CONTADOR'(1);
    endfunction

    branch_hazard_detector #(
        .CANT_BITS_FLAG_BRANCH      (CANT_BITS_FLAG_BRANCH),
        .CANT_BITS_ADDRESS_REGISTROS(CANT_BITS_ADDRESS_REGISTROS)
    ) u_detector (
        .i_flag_branch  (i_flag_branch),
        .i_rs           (i_rs),
        .i_rt           (i_rt),
        .i_ex_reg_write (i_ex_reg_write),
        .i_ex_mem_read  (i_ex_mem_read),
        .i_ex_rd        (i_ex_rd),
        .i_mem_mem_read (i_mem_mem_read),
        .i_mem_rd       (i_mem_rd),
        .o_branch_active(branch_active),
        .o_stall_count  (stall_need)
    );

    // Reset also gates the combinational outputs so nothing leaks while held in reset.
    assign run = i_enable_etapa & i_reset;

    always_comb begin
        state_d        = state_q;
        stall_cnt_d    = stall_cnt_q;
        pc_target_d    = pc_target_q;
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;
        o_stall        = 1'b0;
        o_pc_load      = 1'b0;
        o_flush_if_id  = 1'b0;

        if (run) begin
            case (state_q)
                ST_IDLE: begin
                    if (branch_active) begin
                        if (stall_need != STALL_NONE) begin
                            // The detection cycle is the first stall cycle; a one-deep hazard
                            // is fully covered by it, so the branch is re-evaluated next cycle.
                            o_stall     = 1'b1;
                            stall_cnt_d = stall_need - 2'd1;
                            state_d     = (stall_need == STALL_ONE) ? ST_IDLE : ST_STALL;
                        end else begin
                            branch_count_d = sat_inc(branch_count_q);
                            if (i_branch_control) begin
                                taken_count_d = sat_inc(taken_count_q);
                                pc_target_d   = i_branch_dir;
                                state_d       = ST_REDIRECT;
                            end
                        end
                    end
                end
                ST_STALL: begin
                    o_stall     = 1'b1;
                    stall_cnt_d = stall_cnt_q - 2'd1;
                    if (stall_cnt_q <= 2'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    o_pc_load     = 1'b1;
                    o_flush_if_id = 1'b1;
                    state_d       = ST_IDLE;
                end
                default: begin
                    state_d     = ST_IDLE;
                    stall_cnt_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= ST_IDLE;
            stall_cnt_q    <= 2'd0;
            pc_target_q    <= '0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            stall_cnt_q    <= stall_cnt_d;
            pc_target_q    <= pc_target_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign o_pc_target    = pc_target_q;
    assign o_branch_count = branch_count_q;
    assign o_taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Randomised and directed scoreboard bench for branch_hazard_controller.
// Expected outputs come from a cycle-level model of the branch resolution rules.
module tb_branch_hazard_controller;

    localparam int AW = 11;
    localparam int FW = 3;
    localparam int RW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [FW-1:0] flag;
    logic          ctrl;
    logic [AW-1:0] dir;
    logic [RW-1:0] rs, rt, ex_rd, mem_rd;
    logic          ex_w, ex_r, mem_r;
    logic          o_stall, o_pc_load, o_flush_if_id;
    logic [AW-1:0] o_pc_target;
    logic [CW-1:0] o_branch_count, o_taken_count;

    always #5 clk = ~clk;

    branch_hazard_controller #(
        .CANT_BITS_ADDR             (AW),
        .CANT_BITS_FLAG_BRANCH      (FW),
        .CANT_BITS_ADDRESS_REGISTROS(RW),
        .CANT_BITS_CONTADOR         (CW)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_enable_etapa  (en),
        .i_flag_branch   (flag),
        .i_branch_control(ctrl),
        .i_branch_dir    (dir),
        .i_rs            (rs),
        .i_rt            (rt),
        .i_ex_reg_write  (ex_w),
        .i_ex_mem_read   (ex_r),
        .i_ex_rd         (ex_rd),
        .i_mem_mem_read  (mem_r),
        .i_mem_rd        (mem_rd),
        .o_stall         (o_stall),
        .o_pc_load       (o_pc_load),
        .o_pc_target     (o_pc_target),
        .o_flush_if_id   (o_flush_if_id),
        .o_branch_count  (o_branch_count),
        .o_taken_count   (o_taken_count)
    );

    typedef struct packed {
        logic          en;
        logic [FW-1:0] flag;
        logic          ctrl;
        logic [AW-1:0] dir;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          exw;
        logic          exr;
        logic [RW-1:0] exrd;
        logic          memr;
        logic [RW-1:0] memrd;
    } stim_t;

    typedef struct packed {
        logic          stall;
        logic          load;
        logic          flush;
        logic [AW-1:0] tgt;
        logic [CW-1:0] bc;
        logic [CW-1:0] tc;
    } exp_t;

    exp_t  exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    string phase = "reset";

    // Reference model state: pending stall cycles, pending redirect, statistics.
    int            m_stall_left;
    bit            m_redir;
    int            m_bc, m_tc;
    logic [AW-1:0] m_tgt;

    function automatic int need_stalls(input stim_t s);
        bit rt_used, dep_ex, dep_mem;
        if (s.flag < 1 || s.flag > 5) return 0;
        rt_used = (s.flag == 3) || (s.flag == 4);
        dep_ex  = (s.exrd != 0) && (s.rs == s.exrd || (rt_used && s.rt == s.exrd));
        dep_mem = (s.memrd != 0) && (s.rs == s.memrd || (rt_used && s.rt == s.memrd));
        if (s.exr && dep_ex) return 2;
        if ((s.exw && dep_ex) || (s.memr && dep_mem)) return 1;
        return 0;
    endfunction

    function automatic stim_t mk(input int f, input bit c, input int d, input int a, input int b,
                                 input bit xw, input bit xr, input int xrd, input bit mr, input int mrd);
        stim_t s;
        s.en = 1'b1; s.flag = FW'(f); s.ctrl = c; s.dir = AW'(d);
        s.rs = RW'(a); s.rt = RW'(b); s.exw = xw; s.exr = xr; s.exrd = RW'(xrd);
        s.memr = mr; s.memrd = RW'(mrd);
        return s;
    endfunction

    function automatic stim_t idle_s();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t got;
        got.stall = o_stall; got.load = o_pc_load; got.flush = o_flush_if_id;
        got.tgt = o_pc_target; got.bc = o_branch_count; got.tc = o_taken_count;
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s @%0t: got stall=%b load=%b flush=%b tgt=%h bc=%h tc=%h, expected stall=%b load=%b flush=%b tgt=%h bc=%h tc=%h",
                     name, $time, got.stall, got.load, got.flush, got.tgt, got.bc, got.tc,
                     e.stall, e.load, e.flush, e.tgt, e.bc, e.tc);
        end
    endtask

    task automatic drive(input stim_t s);
        en = s.en; flag = s.flag; ctrl = s.ctrl; dir = s.dir; rs = s.rs; rt = s.rt;
        ex_w = s.exw; ex_r = s.exr; ex_rd = s.exrd; mem_r = s.memr; mem_rd = s.memrd;
    endtask

    task automatic model_reset();
        m_stall_left = 0; m_redir = 0; m_bc = 0; m_tc = 0; m_tgt = '0;
    endtask

    // Drive one cycle of stimulus and push what the outputs must show during it.
    task automatic step(input stim_t s);
        exp_t e;
        int   n;
        drive(s);
        e = '0;
        e.tgt = m_tgt; e.bc = CW'(m_bc); e.tc = CW'(m_tc);
        if (s.en) begin
            if (m_redir) begin
                e.load = 1'b1; e.flush = 1'b1; m_redir = 0;
            end else if (m_stall_left > 0) begin
                e.stall = 1'b1; m_stall_left--;
            end else if (s.flag >= 1 && s.flag <= 5) begin
                n = need_stalls(s);
                if (n > 0) begin
                    e.stall = 1'b1; m_stall_left = n - 1;
                end else begin
                    m_bc = (m_bc == 65535) ? 65535 : m_bc + 1;
                    if (s.ctrl) begin
                        m_tc = (m_tc == 65535) ? 65535 : m_tc + 1;
                        m_tgt = s.dir; m_redir = 1;
                    end
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        step(s);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check(phase, exp_q.pop_front());
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        stim_t s;
        exp_t  zero;
        zero = '0;
        model_reset();
        rst_n = 1'b0;
        drive(mk(4, 1, 'h0AA, 5, 0, 0, 1, 5, 0, 0));
        #12;
        check("reset_outputs", zero);
        @(posedge clk); #2;
        check("reset_hold", zero);
        drive(idle_s());
        @(negedge clk);
        rst_n = 1'b1;

        phase = "beq_taken";
        apply(mk(3, 1, 'h040, 1, 2, 0, 0, 0, 0, 0));
        apply(mk(4, 1, 'h123, 5, 0, 0, 1, 5, 0, 0));   // wrong-path branch during redirect
        apply(idle_s());

        phase = "bne_ex_load";
        apply(mk(4, 1, 'h0AA, 5, 0, 1, 1, 5, 0, 0));
        apply(mk(4, 1, 'h0AA, 5, 0, 1, 1, 5, 0, 0));
        apply(mk(4, 1, 'h0AA, 5, 0, 0, 0, 0, 0, 0));
        apply(idle_s());
        apply(idle_s());

        phase = "beq_ex_alu";
        apply(mk(3, 0, 'h010, 1, 7, 1, 0, 7, 0, 0));
        apply(mk(3, 0, 'h010, 1, 7, 0, 0, 0, 0, 0));
        apply(mk(3, 0, 'h010, 0, 0, 1, 0, 0, 0, 0));
        phase = "j_rt_match";
        apply(mk(5, 1, 'h200, 2, 7, 1, 0, 7, 0, 0));
        apply(idle_s());
        phase = "jr_mem_load";
        apply(mk(1, 1, 'h300, 9, 0, 0, 0, 0, 1, 9));
        apply(mk(1, 1, 'h300, 9, 0, 0, 0, 0, 0, 0));
        apply(idle_s());
        apply(idle_s());

        phase = "enable_freeze";
        apply(mk(4, 1, 'h0CC, 5, 0, 1, 1, 5, 0, 0));
        s = mk(4, 1, 'h0CC, 5, 0, 1, 1, 5, 0, 0);
        s.en = 1'b0;
        repeat (5) apply(s);
        apply(mk(4, 1, 'h0CC, 5, 0, 1, 1, 5, 0, 0));
        apply(mk(4, 1, 'h0CC, 5, 0, 0, 0, 0, 0, 0));
        apply(idle_s());
        apply(idle_s());

        phase = "reset_mid_redirect";
        apply(mk(3, 1, 'h155, 1, 2, 0, 0, 0, 0, 0));
        apply(idle_s());
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_redirect", zero);
        model_reset();
        @(posedge clk); #2;
        check("reset_mid_redirect_hold", zero);
        @(negedge clk);
        rst_n = 1'b1;
        apply(idle_s());

        phase = "saturate";
        @(posedge clk); #1;
        force dut.branch_count_q = '1;
        force dut.taken_count_q  = '1;
        m_bc = 65535; m_tc = 65535;
        step(idle_s());
        @(posedge clk); #1;
        release dut.branch_count_q;
        release dut.taken_count_q;
        step(idle_s());
        apply(mk(3, 1, 'h3FF, 1, 2, 0, 0, 0, 0, 0));
        apply(idle_s());
        apply(mk(4, 0, 'h001, 1, 2, 0, 0, 0, 0, 0));
        apply(idle_s());

        phase = "random";
        repeat (3000) begin
            s.en    = ($urandom_range(0, 9) != 0);
            s.flag  = FW'($urandom_range(0, 7));
            s.ctrl  = 1'($urandom_range(0, 1));
            s.dir   = AW'($urandom);
            s.rs    = RW'($urandom_range(0, 3));
            s.rt    = RW'($urandom_range(0, 3));
            s.exw   = 1'($urandom_range(0, 1));
            s.exr   = ($urandom_range(0, 3) == 0);
            s.exrd  = RW'($urandom_range(0, 3));
            s.memr  = ($urandom_range(0, 3) == 0);
            s.memrd = RW'($urandom_range(0, 3));
            apply(s);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
